// File: rtl/gf_iso_map_pipe.sv
// gf_iso_map_pipe: maps LANES bytes per beat between the GF(2^8) polynomial
// basis and the GF((2^4)^2) composite basis used by the AES S-box inversion
// core. The transform is combinational on the input side and is captured into
// stage 0. The remaining stages form an elastic valid/ready delay line.
module gf_iso_map_pipe #(
   parameter int LANES       = 4,
   parameter int PIPE_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_mode,
   input  logic [8*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         out_mode,
   output logic [8*LANES-1:0] out_data,
   output logic               err_mode,
   output logic [15:0]        beat_cnt
);

   localparam logic [1:0] MODE_FWD = 2'b00;
   localparam logic [1:0] MODE_INV = 2'b01;
   localparam logic [1:0] MODE_RSV = 2'b11;

   // Polynomial basis to composite basis.
   function automatic logic [7:0] fwd_map(input logic [7:0] x);
      logic [7:0] y;
      y[7] = x[5] ^ x[7];
      y[6] = x[2] ^ x[3] ^ x[5] ^ x[7];
      y[5] = x[1] ^ x[4] ^ x[6] ^ x[7];
      y[4] = x[4] ^ x[5] ^ x[6];
      y[3] = x[1] ^ x[3] ^ x[4];
      y[2] = x[5];
      y[1] = x[1] ^ x[2] ^ x[4] ^ x[5] ^ x[6];
      y[0] = x[0] ^ x[1] ^ x[2] ^ x[3] ^ x[4] ^ x[6] ^ x[7];
      return y;
   endfunction

   // Composite basis back to polynomial basis; the GF(2) inverse of fwd_map.
   function automatic logic [7:0] inv_map(input logic [7:0] y);
      logic [7:0] x;
      x[7] = y[2] ^ y[7];
      x[6] = y[1] ^ y[2] ^ y[3] ^ y[6] ^ y[7];
      x[5] = y[2];
      x[4] = y[1] ^ y[3] ^ y[4] ^ y[6] ^ y[7];
      x[3] = y[1] ^ y[5] ^ y[6];
      x[2] = y[1] ^ y[5] ^ y[7];
      x[1] = y[4] ^ y[5] ^ y[7];
      x[0] = y[0] ^ y[5] ^ y[6] ^ y[7];
      return x;
   endfunction

   logic [8*LANES-1:0] mapped;
   logic               st_valid [PIPE_STAGES];
   logic [1:0]         st_mode  [PIPE_STAGES];
   logic [8*LANES-1:0] st_data  [PIPE_STAGES];
   logic               st_load  [PIPE_STAGES];
   logic               accept;

   // Per-lane transform selected by the shared mode; bypass and reserved pass through.
   always_comb begin
      mapped = in_data;
      for (int l = 0; l < LANES; l++) begin
         if (in_mode == MODE_FWD)
            mapped[8*l +: 8] = fwd_map(in_data[8*l +: 8]);
         else if (in_mode == MODE_INV)
            mapped[8*l +: 8] = inv_map(in_data[8*l +: 8]);
      end
   end

   // Ready chain: a stage may load when it is empty or its beat moves on this cycle.
   always_comb begin
      logic ok_next;
      ok_next = out_ready;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         st_load[k] = !st_valid[k] || ok_next;
         ok_next    = st_load[k];
      end
   end

   assign in_ready  = st_load[0];
   assign accept    = in_valid && st_load[0];
   assign out_valid = st_valid[PIPE_STAGES-1];
   assign out_mode  = st_mode[PIPE_STAGES-1];
   assign out_data  = st_data[PIPE_STAGES-1];

   // Stage valid bits; reset discards every beat in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_STAGES; k++)
            st_valid[k] <= 1'b0;
      end else begin
         if (st_load[0])
            st_valid[0] <= accept;
         for (int k = 1; k < PIPE_STAGES; k++) begin
            if (st_load[k])
               st_valid[k] <= st_valid[k-1];
         end
      end
   end

   // Stage payload; only written when a real beat arrives so stalled data holds.
   always_ff @(posedge clk) begin
      if (st_load[0] && accept) begin
         st_mode[0] <= in_mode;
         st_data[0] <= mapped;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
         if (st_load[k] && st_valid[k-1]) begin
            st_mode[k] <= st_mode[k-1];
            st_data[k] <= st_data[k-1];
         end
      end
   end

   // Saturating accepted-beat counter and sticky reserved-mode flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt <= 16'h0000;
         err_mode <= 1'b0;
      end else if (accept) begin
         if (beat_cnt != 16'hFFFF)
            beat_cnt <= beat_cnt + 16'd1;
         if (in_mode == MODE_RSV)
            err_mode <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gf_iso_map_pipe.sv
// Bench for gf_iso_map_pipe: a 4-lane/2-stage instance for directed scenarios
// and a 1-lane/1-stage instance for a long random handshake run.
module tb_gf_iso_map_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // 4-lane, 2-stage instance
   logic        a_rst_n = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [1:0]  a_in_mode = 2'b00;
   logic [31:0] a_in_data = '0;
   logic        a_in_ready, a_out_valid, a_err_mode;
   logic [1:0]  a_out_mode;
   logic [31:0] a_out_data;
   logic [15:0] a_beat_cnt;

   // 1-lane, 1-stage instance
   logic        b_rst_n = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [1:0]  b_in_mode = 2'b00;
   logic [7:0]  b_in_data = '0;
   logic        b_in_ready, b_out_valid, b_err_mode;
   logic [1:0]  b_out_mode;
   logic [7:0]  b_out_data;
   logic [15:0] b_beat_cnt;

   gf_iso_map_pipe #(.LANES(4), .PIPE_STAGES(2)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_mode(a_in_mode), .in_data(a_in_data), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data),
      .err_mode(a_err_mode), .beat_cnt(a_beat_cnt));

   gf_iso_map_pipe #(.LANES(1), .PIPE_STAGES(1)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_mode(b_in_mode), .in_data(b_in_data), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data),
      .err_mode(b_err_mode), .beat_cnt(b_beat_cnt));

   // Reference: each output bit is the parity of the input bits its equation lists.
   function automatic logic [7:0] fwd_ref(input logic [7:0] x);
      logic [7:0] m [8];
      logic [7:0] y;
      m = '{8'hDF, 8'h76, 8'h20, 8'h1A, 8'h70, 8'hD2, 8'hAC, 8'hA0};
      for (int i = 0; i < 8; i++) y[i] = ^(x & m[i]);
      return y;
   endfunction

   // Reference inverse: search for the preimage under the forward map.
   function automatic logic [7:0] inv_ref(input logic [7:0] y);
      for (int v = 0; v < 256; v++) begin
         logic [7:0] c;
         c = 8'(v);
         if (fwd_ref(c) == y) return c;
      end
      return 8'h00;
   endfunction

   function automatic logic [31:0] model_beat(input logic [1:0] m, input logic [31:0] d);
      logic [31:0] r;
      r = d;
      for (int l = 0; l < 4; l++) begin
         if (m == 2'b00)      r[8*l +: 8] = fwd_ref(d[8*l +: 8]);
         else if (m == 2'b01) r[8*l +: 8] = inv_ref(d[8*l +: 8]);
      end
      return r;
   endfunction

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] data;
   } beat_t;

   beat_t       exp_q [$];
   logic [31:0] got_q [$];
   logic [15:0] m_cnt = '0;
   logic        m_err = 1'b0;

   logic        s_in_ready, s_out_valid, s_acc, s_del, s_err;
   logic [1:0]  s_out_mode;
   logic [31:0] s_out_data;
   logic [15:0] s_cnt;

   // One cycle on instance A: drive, sample before the edge, score against the model.
   task automatic step_a(input logic iv, input logic [1:0] im, input logic [31:0] id,
                         input logic ordy);
      beat_t h;
      @(negedge clk);
      a_in_valid = iv; a_in_mode = im; a_in_data = id; a_out_ready = ordy;
      #1;
      s_in_ready = a_in_ready; s_out_valid = a_out_valid;
      s_out_data = a_out_data; s_out_mode = a_out_mode;
      s_err = a_err_mode; s_cnt = a_beat_cnt;
      s_acc = iv && a_in_ready;
      s_del = a_out_valid && ordy;
      n_checks++;
      if (s_cnt !== m_cnt || s_err !== m_err) begin
         n_fail++;
         $display("FAIL a_status: beat_cnt=%h err_mode=%b expected beat_cnt=%h err_mode=%b",
                  s_cnt, s_err, m_cnt, m_err);
      end
      if (a_out_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL a_spurious_beat: out_valid=1 data=%h, expected no beat", a_out_data);
         end else begin
            h = exp_q[0];
            if ({a_out_mode, a_out_data} !== {h.mode, h.data}) begin
               n_fail++;
               $display("FAIL a_beat: mode=%b data=%h expected mode=%b data=%h",
                        a_out_mode, a_out_data, h.mode, h.data);
            end
         end
      end
      if (s_del && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         got_q.push_back(a_out_data);
      end
      if (s_acc) begin
         h.mode = im;
         h.data = model_beat(im, id);
         exp_q.push_back(h);
         if (m_cnt != 16'hFFFF) m_cnt++;
         if (im == 2'b11) m_err = 1'b1;
      end
      @(posedge clk);
   endtask

   task automatic send_a(input logic [1:0] im, input logic [31:0] id);
      int tries;
      tries = 0;
      do begin
         step_a(1'b1, im, id, 1'b1);
         tries++;
      end while (!s_acc && tries < 10);
      n_checks++;
      if (!s_acc) begin
         n_fail++;
         $display("FAIL a_send_timeout: accepted=0 expected 1");
      end
   endtask

   task automatic drain_a;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL a_drain_timeout: %0d beats left expected 0", exp_q.size());
      end
   endtask

   // Reset with a live handshake on the inputs; it must be ignored.
   task automatic reset_a;
      @(negedge clk);
      a_rst_n = 1'b0; a_in_valid = 1'b1; a_in_mode = 2'b11; a_out_ready = 1'b1;
      @(negedge clk);
      a_rst_n = 1'b1; a_in_valid = 1'b0;
      exp_q.delete();
      m_cnt = '0;
      m_err = 1'b0;
   endtask

   task automatic test_reset;
      reset_a();
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b0 || s_err !== 1'b0 || s_cnt !== 16'h0 || s_in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: out_valid=%b err=%b cnt=%h in_ready=%b expected 0 0 0000 1",
                  s_out_valid, s_err, s_cnt, s_in_ready);
      end
   endtask

   task automatic test_forward;
      step_a(1'b1, 2'b00, 32'hFF800201, 1'b1);
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fwd_latency_early: out_valid=%b expected 0", s_out_valid);
      end
      step_a(1'b1, 2'b00, 32'h00000020, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'h1FE12B01 || s_out_mode !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_single: valid=%b data=%h mode=%b expected 1 1fe12b01 00",
                  s_out_valid, s_out_data, s_out_mode);
      end
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b1 || s_out_data[7:0] !== 8'hD6) begin
         n_fail++;
         $display("FAIL fwd_lane0_20: valid=%b lane0=%h expected 1 d6", s_out_valid, s_out_data[7:0]);
      end
      drain_a();
   endtask

   task automatic test_inverse;
      logic [31:0] fwd_out [$];
      bit          seen [256];
      int          distinct;
      step_a(1'b1, 2'b01, {8'h00, 8'hD6, 8'hE1, 8'h2B}, 1'b1);
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'h00208002 || s_out_mode !== 2'b01) begin
         n_fail++;
         $display("FAIL inv_single: valid=%b data=%h mode=%b expected 1 00208002 01",
                  s_out_valid, s_out_data, s_out_mode);
      end
      drain_a();
      got_q.delete();
      for (int b = 0; b < 64; b++) begin
         logic [31:0] d;
         for (int l = 0; l < 4; l++) d[8*l +: 8] = 8'(4*b + l);
         send_a(2'b00, d);
      end
      drain_a();
      fwd_out = got_q;
      n_checks++;
      if (fwd_out.size() != 64) begin
         n_fail++;
         $display("FAIL roundtrip_fwd_count: %0d beats expected 64", fwd_out.size());
      end else begin
         distinct = 0;
         for (int k = 0; k < 256; k++) seen[k] = 1'b0;
         for (int k = 0; k < 256; k++) begin
            logic [7:0] v;
            v = fwd_out[k/4][8*(k%4) +: 8];
            if (!seen[v]) distinct++;
            seen[v] = 1'b1;
         end
         n_checks++;
         if (distinct != 256) begin
            n_fail++;
            $display("FAIL fwd_bijection: %0d distinct outputs expected 256", distinct);
         end
         got_q.delete();
         for (int b = 0; b < 64; b++) send_a(2'b01, fwd_out[b]);
         drain_a();
         n_checks++;
         if (got_q.size() != 64) begin
            n_fail++;
            $display("FAIL roundtrip_inv_count: %0d beats expected 64", got_q.size());
         end else begin
            for (int k = 0; k < 256; k++) begin
               n_checks++;
               if (got_q[k/4][8*(k%4) +: 8] !== 8'(k)) begin
                  n_fail++;
                  $display("FAIL roundtrip_byte: got %h expected %h",
                           got_q[k/4][8*(k%4) +: 8], 8'(k));
               end
            end
         end
      end
   endtask

   task automatic test_back_pressure;
      logic [31:0] d [5];
      logic [1:0]  m [5];
      int          nacc, idx;
      reset_a();
      for (int i = 0; i < 5; i++) begin
         d[i] = $urandom;
         m[i] = 2'($urandom_range(0, 2));
      end
      nacc = 0;
      for (int c = 0; c < 5; c++) begin
         idx = (nacc < 5) ? nacc : 0;
         step_a(nacc < 5, m[idx], d[idx], 1'b0);
         if (s_acc) nacc++;
      end
      n_checks++;
      if (nacc != 2 || s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL bp_full: accepted=%0d in_ready=%b out_valid=%b cnt=%h expected 2 0 1 0002",
                  nacc, s_in_ready, s_out_valid, s_cnt);
      end
      idx = (nacc < 5) ? nacc : 0;
      step_a(nacc < 5, m[idx], d[idx], 1'b1);
      n_checks++;
      if (s_in_ready !== 1'b1 || s_acc !== 1'b1 || s_del !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_same_cycle: in_ready=%b acc=%b del=%b expected 1 1 1",
                  s_in_ready, s_acc, s_del);
      end
      if (s_acc) nacc++;
      for (int c = 0; c < 20 && nacc < 5; c++) begin
         idx = (nacc < 5) ? nacc : 0;
         step_a(1'b1, m[idx], d[idx], 1'b1);
         if (s_acc) nacc++;
      end
      drain_a();
      n_checks++;
      if (nacc != 5 || s_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL bp_count: accepted=%0d cnt=%h expected 5 0005", nacc, s_cnt);
      end
   endtask

   task automatic test_reserved;
      step_a(1'b1, 2'b11, 32'h12345678, 1'b1);
      n_checks++;
      if (s_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rsv_err_early: err_mode=%b expected 0", s_err);
      end
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_err !== 1'b1) begin
         n_fail++;
         $display("FAIL rsv_err_set: err_mode=%b expected 1", s_err);
      end
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'h12345678 || s_out_mode !== 2'b11) begin
         n_fail++;
         $display("FAIL rsv_beat: valid=%b data=%h mode=%b expected 1 12345678 11",
                  s_out_valid, s_out_data, s_out_mode);
      end
      drain_a();
   endtask

   task automatic test_reset_in_flight;
      step_a(1'b1, 2'b00, $urandom, 1'b0);
      step_a(1'b1, 2'b01, $urandom, 1'b0);
      reset_a();
      for (int c = 0; c < 4; c++) begin
         step_a(1'b0, 2'b00, 32'h0, 1'b1);
         n_checks++;
         if (s_out_valid !== 1'b0 || s_err !== 1'b0 || s_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_in_flight: out_valid=%b err=%b cnt=%h expected 0 0 0000",
                     s_out_valid, s_err, s_cnt);
         end
      end
   endtask

   task automatic test_saturation;
      #1;
      force dut_a.beat_cnt = 16'hFFFE;
      #1;
      release dut_a.beat_cnt;
      m_cnt = 16'hFFFE;
      for (int i = 0; i < 3; i++) send_a(2'($urandom_range(0, 2)), $urandom);
      step_a(1'b0, 2'b00, 32'h0, 1'b1);
      n_checks++;
      if (s_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL cnt_saturate: beat_cnt=%h expected ffff", s_cnt);
      end
      drain_a();
   endtask

   // Minimum configuration under random handshakes against a queue model.
   task automatic test_random_min;
      beat_t       q [$];
      beat_t       h;
      int          acc_n;
      logic        e_err, iv, ordy, exp_rdy;
      logic [1:0]  im;
      logic [7:0]  id;
      @(negedge clk);
      b_rst_n = 1'b0;
      @(negedge clk);
      b_rst_n = 1'b1;
      acc_n = 0;
      e_err = 1'b0;
      for (int c = 0; c < 10000 + 20; c++) begin
         @(negedge clk);
         iv   = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
         ordy = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
         im   = 2'($urandom_range(0, 3));
         id   = 8'($urandom);
         b_in_valid = iv; b_in_mode = im; b_in_data = id; b_out_ready = ordy;
         #1;
         exp_rdy = (q.size() == 0) || ordy;
         n_checks++;
         if (b_in_ready !== exp_rdy || b_out_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL b_handshake: in_ready=%b out_valid=%b expected %b %b",
                     b_in_ready, b_out_valid, exp_rdy, q.size() != 0);
         end
         if (b_out_valid && q.size() > 0) begin
            h = q[0];
            n_checks++;
            if ({b_out_mode, b_out_data} !== {h.mode, h.data[7:0]}) begin
               n_fail++;
               $display("FAIL b_beat: mode=%b data=%h expected mode=%b data=%h",
                        b_out_mode, b_out_data, h.mode, h.data[7:0]);
            end
            if (ordy) void'(q.pop_front());
         end
         if (iv && b_in_ready) begin
            h.mode = im;
            h.data = model_beat(im, {24'h0, id});
            q.push_back(h);
            acc_n++;
            if (im == 2'b11) e_err = 1'b1;
         end
      end
      n_checks++;
      if (q.size() != 0 || b_beat_cnt !== 16'(acc_n) || b_err_mode !== e_err) begin
         n_fail++;
         $display("FAIL b_final: left=%0d cnt=%h err=%b expected 0 %h %b",
                  q.size(), b_beat_cnt, b_err_mode, 16'(acc_n), e_err);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_back_pressure();
      test_reserved();
      test_reset_in_flight();
      test_saturation();
      test_random_min();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gf_iso_map_pipe.md
# gf_iso_map_pipe

Parametrised, pipelined successor of the single-byte GF(2^8) to GF((2^4)^2) isomorphism used by the composite-field AES S-box. It maps LANES bytes per beat. Each beat selects one of three modes:
- forward map (polynomial basis to composite basis);
- inverse map (composite basis back to polynomial basis);
- bypass.

A valid/ready elastic pipeline of PIPE_STAGES register stages carries the beats, so the block sits between the AES state/key datapath and the GF(16) inversion core and absorbs back-pressure.

## Interface
- LANES, default 4: bytes per beat, legal range 1..16.
- PIPE_STAGES, default 2: register stages, legal range 1..4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_mode  input  2  00 = forward, 01 = inverse, 10 = bypass, 11 = reserved.
- in_data  input  8*LANES  lane i occupies bits [8i+7:8i].
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts the beat.
- out_mode  output  2  in_mode carried alongside its beat.
- out_data  output  8*LANES  transformed lanes.
- err_mode  output  1  sticky flag: a mode-11 beat was accepted.
- beat_cnt  output  16  accepted-beat counter, saturating.

## Operation
- **Forward map, per lane.** Input x, output y:
  - y7 = x5^x7
  - y6 = x2^x3^x5^x7
  - y5 = x1^x4^x6^x7
  - y4 = x4^x5^x6
  - y3 = x1^x3^x4
  - y2 = x5
  - y1 = x1^x2^x4^x5^x6
  - y0 = x0^x1^x2^x3^x4^x6^x7
- **Inverse map.** The exact GF(2) matrix inverse of the forward map. inverse(forward(x)) = x for all 256 values. Implemented as fixed XOR equations; no lookup table.
- **Bypass.** y = x.
- **Reserved mode 11.** Treated as bypass. On acceptance it sets err_mode. out_mode still reports 11.
- **Lanes.** All lanes share one mode and are independent. LANES=1 must behave identically to lane 0 of any wider configuration.
- **Where the transform sits.** It is combinational on the input side and is captured into stage 0. Later stages only delay data and mode.
- **Stage behaviour.** Each stage holds {valid, mode, data}.
  - Stage k loads from stage k-1 when it is empty or its contents are leaving this cycle.
  - Data in a stalled stage holds stable.
- **Ready and handshake.**
  - in_ready = !stage0_valid || stage0 leaving this cycle. Ready propagates combinationally from out_ready back through the stages.
  - A beat is accepted when in_valid && in_ready. It is delivered when out_valid && out_ready.
  - Once out_valid is high, out_valid, out_data and out_mode stay stable until the beat is delivered.
- **beat_cnt.** Increments by 1 per accepted beat and saturates at 0xFFFF (never wraps).
- **err_mode.** Cleared only by reset.
- **Reset.** rst_n low at a clock edge clears the following, regardless of handshakes in the same cycle; beats in flight are discarded:
  - all stage valids;
  - err_mode;
  - beat_cnt.

  The data and mode registers need no reset.

## Timing
- **Reset values.**
  - out_valid = 0, err_mode = 0, beat_cnt = 0.
  - out_data and out_mode are don't-care while out_valid = 0.
  - in_ready = 1 from the first cycle after reset.
- **Latency.** Exactly PIPE_STAGES cycles from acceptance to out_valid when there is no back-pressure.
- **Throughput.** One beat per cycle while out_ready = 1.
- **Capacity.** The block holds at most PIPE_STAGES beats.
  - With out_ready held low, in_ready falls after PIPE_STAGES beats have been accepted.
  - When out_ready returns high, in_ready goes high in the same cycle.
- **Ordering.** Beats leave in acceptance order, with no duplication and no loss, for any pattern of in_valid and out_ready.
- **Simultaneous accept and deliver with the pipe full.** Both complete in the same cycle.
- **Stall without deliver.** If out_ready = 0, in_valid = 1 and the pipe is full, nothing is accepted and beat_cnt does not change.
- **Counter update.** beat_cnt and err_mode update on the clock edge of acceptance and are visible the next cycle.

## Test plan
- **Forward mode, single beat.** LANES=4, PIPE_STAGES=2, out_ready = 1, mode 00, in_data 0xFF_80_02_01 -> after 2 cycles out_data = 0x1F_E1_2B_01, out_mode = 00. A follow-on beat with lane 0 = 0x20 -> lane 0 output 0xD6.
- **Inverse mode and round-trip.** Mode 01 with lanes {0x2B, 0xE1, 0xD6, 0x00} -> {0x02, 0x80, 0x20, 0x00}. Stream all 256 bytes through forward then inverse -> identity, and forward is a bijection.
- **Back-pressure.** Hold out_ready = 0 and stream 5 beats -> in_ready drops after 2 accepted. Release out_ready -> all beats emerge in order with stable data while stalled, and beat_cnt = 5 at the end.
- **Reserved mode and reset.**
  - A beat with mode 11 and data 0x12345678 -> output 0x12345678, out_mode 11, err_mode = 1 from the next cycle.
  - Assert rst_n = 0 for one cycle with 2 beats in flight -> out_valid = 0, err_mode = 0, beat_cnt = 0 afterwards; no stale beat appears.
- **Random handshake, minimum configuration.** LANES=1, PIPE_STAGES=1, random in_valid and out_ready over 10k cycles -> scoreboard matches a reference model, with no loss and no reordering.
- **Counter saturation.** Preload beat_cnt to 0xFFFE via a bench force, then accept 3 beats -> 0xFFFF, holds.
